// File: rtl/bus_arbiter_3_if.sv
// rtl/bus_arbiter_3_if.sv - request/grant bundle between three bus masters and the arbiter
interface bus_arbiter_3_if #(
  parameter int CNT_W = 4
);
  logic             m0_req;
  logic             m1_req;
  logic             m2_req;
  logic             m0_grant;
  logic             m1_grant;
  logic             m2_grant;
  logic [1:0]       grant_id;
  logic             bus_busy;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output m0_req, m1_req, m2_req,
    input  m0_grant, m1_grant, m2_grant, grant_id, bus_busy, hold_cnt
  );

  modport slave (
    input  m0_req, m1_req, m2_req,
    output m0_grant, m1_grant, m2_grant, grant_id, bus_busy, hold_cnt
  );
endinterface

// File: rtl/bus_arbiter_3.sv
// rtl/bus_arbiter_3.sv - fixed-priority 3-master arbiter with hold limit, parked on m0
module bus_arbiter_3 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  bus_arbiter_3_if.slave  bus
);

  typedef enum logic [1:0] {
    G0 = 2'd0,
    G1 = 2'd1,
    G2 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? CNT_W'(0) : CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [2:0]       grant_q;
  logic [1:0]       grant_id_q;
  logic [CNT_W-1:0] hold_q;

  logic [2:0] req;
  logic       own_req;
  logic       others;
  logic       forced;
  state_t     pick_any;
  state_t     pick_other;
  state_t     target;

  assign req = {bus.m2_req, bus.m1_req, bus.m0_req};

  function automatic logic [2:0] grant_of(state_t s);
    case (s)
      G0:      return 3'b001;
      G1:      return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  always_comb begin
    own_req    = 1'b0;
    others     = 1'b0;
    pick_other = G0;
    case (state)
      G0: begin
        own_req    = req[0];
        others     = req[1] | req[2];
        pick_other = req[1] ? G1 : G2;
      end
      G1: begin
        own_req    = req[1];
        others     = req[0] | req[2];
        pick_other = req[0] ? G0 : G2;
      end
      default: begin
        own_req    = req[2];
        others     = req[0] | req[1];
        pick_other = req[0] ? G0 : G1;
      end
    endcase
  end

  // With no request at all this falls through to G0, which is the park state.
  always_comb begin
    pick_any = G0;
    if (req[0])      pick_any = G0;
    else if (req[1]) pick_any = G1;
    else if (req[2]) pick_any = G2;
  end

  assign forced = (MAX_HOLD != 0) && own_req && others && (hold_q == HOLD_LAST);
  // pick_other is only taken when the owner still requests, i.e. a forced release.
  assign target = own_req ? pick_other : pick_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= G0;
      grant_q    <= 3'b001;
      grant_id_q <= 2'd0;
      hold_q     <= '0;
    end else if (own_req && !forced) begin
      if (hold_q != HOLD_SAT) begin
        hold_q <= hold_q + 1'b1;
      end
    end else begin
      state      <= target;
      grant_q    <= grant_of(target);
      grant_id_q <= target;
      hold_q     <= '0;
    end
  end

  assign bus.m0_grant = grant_q[0];
  assign bus.m1_grant = grant_q[1];
  assign bus.m2_grant = grant_q[2];
  assign bus.grant_id = grant_id_q;
  assign bus.hold_cnt = hold_q;
  assign bus.bus_busy = own_req;

endmodule

// File: tb/tb_bus_arbiter_3.sv
// tb/tb_bus_arbiter_3.sv - random and directed checks of bus_arbiter_3 against a reference model
module tb_bus_arbiter_3;

  logic clk;
  logic reset_n;

  bus_arbiter_3_if #(.CNT_W(4)) ifa ();
  bus_arbiter_3_if #(.CNT_W(4)) ifb ();

  bus_arbiter_3 #(.MAX_HOLD(8), .CNT_W(4)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  bus_arbiter_3 #(.MAX_HOLD(0), .CNT_W(4)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  int checks = 0;
  int errors = 0;

  // Reference model: owner index and hold count per instance (a: limit 8, b: no limit).
  int         own [2];
  int         cnt [2];
  int         lim [2] = '{8, 0};
  logic [2:0] cur_req;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_reqs(input logic [2:0] r);
    cur_req    = r;
    ifa.m0_req = r[0];
    ifa.m1_req = r[1];
    ifa.m2_req = r[2];
    ifb.m0_req = r[0];
    ifb.m1_req = r[1];
    ifb.m2_req = r[2];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = 0;
      cnt[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [2:0] r);
    int  o;
    bit  oth;
    bit  found;
    int  nxt;
    o     = own[k];
    oth   = 1'b0;
    found = 1'b0;
    nxt   = 0;
    for (int i = 0; i < 3; i++) if (i != o && r[i]) oth = 1'b1;
    if (r[o] && !(lim[k] != 0 && oth && cnt[k] == lim[k] - 1)) begin
      cnt[k] = (cnt[k] == 15) ? 15 : cnt[k] + 1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!found && r[i] && i != o) begin
          nxt   = i;
          found = 1'b1;
        end
      end
      own[k] = found ? nxt : 0;
      cnt[k] = 0;
    end
  endtask

  task automatic check_dut(input int k);
    logic [2:0] g;
    logic [1:0] id;
    logic       busy;
    logic [3:0] hc;
    string      p;
    if (k == 0) begin
      g = {ifa.m2_grant, ifa.m1_grant, ifa.m0_grant};
      id = ifa.grant_id; busy = ifa.bus_busy; hc = ifa.hold_cnt; p = "a";
    end else begin
      g = {ifb.m2_grant, ifb.m1_grant, ifb.m0_grant};
      id = ifb.grant_id; busy = ifb.bus_busy; hc = ifb.hold_cnt; p = "b";
    end
    check({p, "_onehot"},   32'($onehot(g)), 32'd1);
    check({p, "_grant"},    32'(g), 32'(3'b001 << own[k]));
    check({p, "_grant_id"}, 32'(id), 32'(own[k]));
    check({p, "_hold_cnt"}, 32'(hc), 32'(cnt[k]));
    check({p, "_bus_busy"}, 32'(busy), 32'(cur_req[own[k]]));
  endtask

  task automatic step(input logic [2:0] r);
    set_reqs(r);
    @(posedge clk);
    model_step(0, r);
    model_step(1, r);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    logic [2:0] r;
    reset_n = 1'b0;
    set_reqs(3'b111);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_m0_grant", 32'(ifa.m0_grant), 32'd1);
    check("rst_grant_id", 32'(ifa.grant_id), 32'd0);
    check("rst_hold_cnt", 32'(ifa.hold_cnt), 32'd0);
    check_dut(0);
    check_dut(1);

    set_reqs(3'b000);
    #2 reset_n = 1'b1;
    step(3'b000);
    check("park_busy", 32'(ifa.bus_busy), 32'd0);

    // Simultaneous m1/m2 requests, then hand-over down the priority chain.
    step(3'b110);
    check("prio_m1_grant", 32'(ifa.m1_grant), 32'd1);
    check("prio_m1_id", 32'(ifa.grant_id), 32'd1);
    step(3'b100);
    check("prio_m2_grant", 32'(ifa.m2_grant), 32'd1);
    check("prio_m2_id", 32'(ifa.grant_id), 32'd2);
    step(3'b000);
    check("prio_park", 32'(ifa.m0_grant), 32'd1);

    // m0 arrives mid-tenure of m2 but must wait for m2 to drop.
    step(3'b100);
    step(3'b100);
    step(3'b100);
    check("nopre_cnt2", 32'(ifa.hold_cnt), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(3'b101);
      check("nopre_m2_kept", 32'(ifa.m2_grant), 32'd1);
    end
    step(3'b001);
    check("nopre_m0_after", 32'(ifa.m0_grant), 32'd1);
    step(3'b000);

    // Hold limit on instance a: m2 keeps 8 cycles, then m1 takes over.
    step(3'b100);
    check("hold_start", 32'(ifa.hold_cnt), 32'd0);
    for (int i = 1; i < 8; i++) begin
      step(3'b110);
      check("hold_m2_kept", 32'(ifa.m2_grant), 32'd1);
      check("hold_cnt_run", 32'(ifa.hold_cnt), 32'(i));
    end
    step(3'b110);
    check("hold_m1_wins", 32'(ifa.m1_grant), 32'd1);
    check("hold_cnt_zero", 32'(ifa.hold_cnt), 32'd0);
    check("nolim_m2_kept", 32'(ifb.m2_grant), 32'd1);
    step(3'b000);

    // Limit disabled on instance b: m1 holds against m0 and the counter saturates.
    step(3'b010);
    for (int i = 0; i < 40; i++) step(3'b011);
    check("nolim_m1_kept", 32'(ifb.m1_grant), 32'd1);
    check("nolim_saturate", 32'(ifb.hold_cnt), 32'd15);
    step(3'b000);

    // Asynchronous reset in the middle of an m2 tenure.
    step(3'b100);
    for (int i = 0; i < 5; i++) step(3'b100);
    check("arst_pre_cnt", 32'(ifa.hold_cnt), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_m0_grant", 32'(ifa.m0_grant), 32'd1);
    check("arst_m2_grant", 32'(ifa.m2_grant), 32'd0);
    check("arst_hold_cnt", 32'(ifa.hold_cnt), 32'd0);
    check_dut(0);
    check_dut(1);
    #1 reset_n = 1'b1;

    // Random request patterns; each request toggles with probability 1/4.
    r = 3'b000;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      end
      step(r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_3.md
Name: bus_arbiter_3

Overview:
- Three-master bus arbiter that generates the one-hot grants m0_grant/m1_grant/m2_grant.
- These grants steer the shared 8-bit address/data muxes onto the slave-side bus.
- Fixed priority m0 > m1 > m2, with a hold-timer that forces the current owner off after MAX_HOLD cycles when another master is waiting, so low-priority masters cannot starve.
- The arbiter parks the grant on m0 when the bus is idle, so the downstream mux always has exactly one selected source.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one master keeps the bus while another request is pending. 0 disables the limit.
- CNT_W, 4: hold counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- m0_req  input  1  master 0 bus request, level.
- m1_req  input  1  master 1 bus request, level.
- m2_req  input  1  master 2 bus request, level.
- m0_grant  output  1  master 0 owns bus (registered).
- m1_grant  output  1  master 1 owns bus (registered).
- m2_grant  output  1  master 2 owns bus (registered).
- grant_id  output  2  encoded owner: 0=m0, 1=m1, 2=m2. Never 3.
- bus_busy  output  1  combinational; 1 when the current owner's req is high.
- hold_cnt  output  CNT_W  cycles the current owner has held the bus with its req high.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - m0_grant=1, m1_grant=0, m2_grant=0.
  - grant_id=0, hold_cnt=0.
  - bus_busy then follows m0_req.
- Grant invariant: exactly one grant high in every cycle, including during reset. All grant outputs are registered.
- State machine, states G0/G1/G2 (owner = m0/m1/m2):
  - G0 is the reset and park state.
  - The next state is evaluated on every rising clk edge.
- Let own_req be the current owner's req, and others be the OR of the other two reqs.
- Forced release is required when all of these hold:
  - MAX_HOLD != 0,
  - own_req = 1,
  - others = 1,
  - hold_cnt == MAX_HOLD-1.
- Transition rules, in order:
  - a) own_req=1 and no forced release: stay in the current state; hold_cnt increments, saturating at 2^CNT_W-1.
  - b) Forced release: move to the highest-priority requesting master other than the current owner; hold_cnt=0.
  - c) own_req=0 and some req high: move to the highest-priority requesting master (m0>m1>m2); hold_cnt=0.
  - d) No req high: go to G0 (park); hold_cnt=0.
- Latency:
  - A request arriving to an idle bus is granted on the first rising edge where it is sampled high (1-cycle latency).
  - Preemption never happens mid-tenure purely on priority. A higher-priority request waits until the owner drops req or the hold limit expires.
- Released master:
  - After a forced release, the released master may re-win only by normal priority once the new owner drops req or is itself force-released.
  - There is no extra fairness memory.
- Simultaneous events:
  - Owner dropping req in the same cycle as a forced release is handled by rule c; the result is identical to b except that the owner may not be excluded (irrelevant, since its req=0).
  - Multiple new requests arriving together: priority order decides.
- Park case: while in G0 and m0_req=0, bus_busy=0. A m0_req rising edge in G0 still takes 1 edge before hold_cnt starts counting; the grant itself is already 1.
- Reset mid-tenure: the grant immediately returns to m0 and hold_cnt to 0, regardless of the requests.
- Request inputs are assumed synchronous to clk; no internal synchronizers.

Test Plan:
- Reset check: hold reset_n=0 with all reqs=1 -> m0_grant=1, grant_id=0, hold_cnt=0. Release reset with reqs=0 -> stays G0 and bus_busy=0.
- Priority: from idle, assert m1_req and m2_req in the same cycle -> next edge m1_grant=1, grant_id=1. Drop m1_req -> next edge m2_grant=1, grant_id=2. Drop m2_req -> next edge m0_grant=1 (park).
- No preemption: m2 owns the bus and m0_req rises at hold_cnt=2 -> m2 keeps the grant until it drops req (MAX_HOLD=8 not reached). Next edge after the drop: m0_grant=1.
- Hold limit: MAX_HOLD=8, m2_req and m1_req held high continuously from m2 ownership -> m2_grant stays high while hold_cnt goes 0..7. Next edge: m1_grant=1, hold_cnt=0.
- Limit disabled: MAX_HOLD=0, m1 owns with m0_req held high for 40 cycles -> m1 keeps the grant and hold_cnt saturates at 15.
- Async reset mid-tenure: m2 owns with hold_cnt=5; pulse reset_n low between clock edges -> grants switch to m0 immediately and hold_cnt=0 without waiting for clk. The one-hot invariant is checked every cycle across all tests.
